cache_arbiter: RTL

- Shares the single physical-memory port between the instruction cache (read-only) and the data cache (read/write) in the mp3 top level.
- Accepts 256-bit line transactions from both caches, grants one at a time with round-robin on conflict, and latches the winning request.
- Drives pmem_* toward physical_memory and routes the response back to the granted cache only.
- Makes the memory-side pmem_* handshake observed by the top-level bench identical to a single-cache system.

---
 rtl/rv32i_types.sv | 17 +
 rtl/cache_arbiter_control.sv | 58 +++++
 rtl/cache_arbiter.sv | 72 +++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared mp3 type package: arbiter state/op encodings and the cache line width.
package rv32i_types;

    localparam int unsigned LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    typedef enum logic {
        MEM_READ,
        MEM_WRITE
    } mem_op_t;

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM: round-robin grant between icache and dcache, one transaction at a time.
module cache_arbiter_control
    import rv32i_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       pmem_resp,
    output arb_state_t state,
    output logic       grant_i,
    output logic       grant_d
);

    // Priority only flips on a real conflict; lone grants leave the pointer alone.
    logic last_grant_d;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == ARB_IDLE) begin
            if (i_req && d_req) begin
                grant_i = last_grant_d;
                grant_d = !last_grant_d;
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_IDLE;
            last_grant_d <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_i) begin
                        state <= ARB_SERVE_I;
                    end else if (grant_d) begin
                        state <= ARB_SERVE_D;
                    end
                    if (i_req && d_req) begin
                        last_grant_d <= grant_d;
                    end
                end
                ARB_SERVE_I, ARB_SERVE_D: begin
                    if (pmem_resp) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the physical memory port between icache and dcache; latches the granted request.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = rv32i_types::LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t            state;
    logic                  grant_i;
    logic                  grant_d;
    mem_op_t               op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    cache_arbiter_control u_control (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_read),
        .d_req     (d_read | d_write),
        .pmem_resp (pmem_resp),
        .state     (state),
        .grant_i   (grant_i),
        .grant_d   (grant_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= MEM_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_i) begin
            op_q   <= MEM_READ;
            addr_q <= i_address;
        end else if (grant_d) begin
            op_q    <= d_write ? MEM_WRITE : MEM_READ;
            addr_q  <= d_address;
            wdata_q <= d_wdata;
        end
    end

    always_comb begin
        pmem_read    = (state != ARB_IDLE) && (op_q == MEM_READ);
        pmem_write   = (state != ARB_IDLE) && (op_q == MEM_WRITE);
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        i_rdata      = pmem_rdata;
        d_rdata      = pmem_rdata;
        i_resp       = (state == ARB_SERVE_I) && pmem_resp;
        d_resp       = (state == ARB_SERVE_D) && pmem_resp;
    end

endmodule
